// File: rtl/temp_disp_pkg.sv
// Shared types and sizing helpers for the temperature display path.
package temp_disp_pkg;

  // Converter sequencing states
  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } conv_state_e;

  localparam int BCD_W = 4;

  // Number of decimal digits needed to hold the largest unsigned value of a given width
  function automatic int bcdDigits(input int dataW);
    longint maxVal;
    int     digits;
    maxVal = (longint'(1) << dataW) - 1;
    digits = 1;
    while (maxVal >= 10) begin
      maxVal = maxVal / 10;
      digits++;
    end
    return digits;
  endfunction

  // Accumulator width in bits: wide enough for the whole conversion result, and never
  // narrower than the display so the display slice is always available
  function automatic int accWidth(input int dataW, input int numDigits);
    int digits;
    digits = bcdDigits(dataW);
    if (numDigits > digits) begin
      digits = numDigits;
    end
    return digits * BCD_W;
  endfunction

endpackage

// File: rtl/temp_display_scanner_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Accepts a sample in IDLE, converts for DATA_W cycles, then presents the
// clamped display digits and the overflow flag for one COMMIT cycle.
module bin2bcd_seq
  import temp_disp_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [DATA_W-1:0]             bin_i,
  output logic                          ready_o,
  output logic                          done_o,
  output logic [NUM_DIGITS*BCD_W-1:0]   bcd_o,
  output logic                          ovf_o
);

  localparam int ACC_W      = accWidth(DATA_W, NUM_DIGITS);
  localparam int ACC_DIGITS = ACC_W / BCD_W;
  localparam int DISP_W     = NUM_DIGITS * BCD_W;
  localparam int CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  conv_state_e        state_q, state_d;
  logic [DATA_W-1:0]  binShift_q, binShift_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   accAdj;
  logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
  logic               accOvf;

  // Add-3 correction: every nibble of 5 or more would exceed 9 after the doubling shift
  always_comb begin
    accAdj = acc_q;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      if (acc_q[i*BCD_W +: BCD_W] >= 4'd5) begin
        accAdj[i*BCD_W +: BCD_W] = acc_q[i*BCD_W +: BCD_W] + 4'd3;
      end
    end
  end

  // Next-state and handshake logic for the IDLE/CONVERT/COMMIT sequence
  always_comb begin
    state_d    = state_q;
    binShift_d = binShift_q;
    acc_d      = acc_q;
    bitCnt_d   = bitCnt_q;
    ready_o    = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          binShift_d = bin_i;
          acc_d      = '0;
          bitCnt_d   = '0;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        acc_d      = {accAdj[ACC_W-2:0], binShift_q[DATA_W-1]};
        binShift_d = binShift_q << 1;
        bitCnt_d   = bitCnt_q + 1'b1;
        if (bitCnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      binShift_q <= '0;
      acc_q      <= '0;
      bitCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      binShift_q <= binShift_d;
      acc_q      <= acc_d;
      bitCnt_q   <= bitCnt_d;
    end
  end

  // Any nonzero nibble above the displayed ones means the value does not fit
  if (ACC_W > DISP_W) begin : gOvf
    assign accOvf = |acc_q[ACC_W-1:DISP_W];
  end else begin : gNoOvf
    assign accOvf = 1'b0;
  end

  assign ovf_o = accOvf;
  assign bcd_o = accOvf ? {NUM_DIGITS{4'd9}} : acc_q[DISP_W-1:0];

endmodule

// File: rtl/temp_display_scanner.sv
// Temperature display front end: accepts a binary reading, converts it to BCD
// in the background and time-multiplexes the digits onto a shared BCD bus
// with an active-low digit select, optionally blanking leading zeros.
module temp_display_scanner
  import temp_disp_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int NUM_DIGITS    = 3,
  parameter int REFRESH_DIV   = 1000,
  parameter int BLANK_LEADING = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     temp_bin,
  input  logic                  temp_valid,
  output logic                  temp_ready,
  output logic                  A,
  output logic                  B,
  output logic                  C,
  output logic                  D,
  output logic [NUM_DIGITS-1:0] cs_n,
  output logic                  ovf
);

  localparam int DISP_W = NUM_DIGITS * BCD_W;
  localparam int PRE_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SEL_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                  convReady;
  logic                  convDone;
  logic [DISP_W-1:0]     convBcd;
  logic                  convOvf;

  logic [DISP_W-1:0]     display_q, display_d;
  logic                  ovf_q, ovf_d;
  logic [PRE_W-1:0]      prescaler_q, prescaler_d;
  logic [SEL_W-1:0]      digitSel_q, digitSel_d;
  logic                  prescalerWrap;
  logic [NUM_DIGITS-1:0] blankMask;
  logic                  higherZero;
  logic [BCD_W-1:0]      bcdOut_q, bcdOut_d;
  logic [NUM_DIGITS-1:0] csN_q, csN_d;

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (temp_valid),
    .bin_i   (temp_bin),
    .ready_o (convReady),
    .done_o  (convDone),
    .bcd_o   (convBcd),
    .ovf_o   (convOvf)
  );

  // The display keeps its old value until the converter finishes a whole sample
  always_comb begin
    display_d = display_q;
    ovf_d     = ovf_q;
    if (convDone) begin
      display_d = convBcd;
      ovf_d     = convOvf;
    end
  end

  // Prescaler sets the slot length; digit select advances once per slot
  always_comb begin
    prescalerWrap = (prescaler_q == PRE_W'(REFRESH_DIV - 1));
    prescaler_d   = prescalerWrap ? '0 : prescaler_q + 1'b1;
    digitSel_d    = digitSel_q;
    if (prescalerWrap) begin
      digitSel_d = (digitSel_q == SEL_W'(NUM_DIGITS - 1)) ? '0 : digitSel_q + 1'b1;
    end
  end

  // A digit is blank when it and every more significant digit are zero; units never blank
  always_comb begin
    higherZero = 1'b1;
    blankMask  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      higherZero   = higherZero & (display_q[k*BCD_W +: BCD_W] == 4'd0);
      blankMask[k] = (BLANK_LEADING != 0) && (k != 0) && higherZero;
    end
  end

  // Next bus value and select pattern for the digit currently being scanned
  always_comb begin
    bcdOut_d = display_q[int'(digitSel_q)*BCD_W +: BCD_W];
    csN_d    = '1;
    if (!blankMask[digitSel_q]) begin
      csN_d[digitSel_q] = 1'b0;
    end
  end

  // All display-side state, reset to a dark, zeroed display
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      display_q   <= '0;
      ovf_q       <= 1'b0;
      prescaler_q <= '0;
      digitSel_q  <= '0;
      bcdOut_q    <= '0;
      csN_q       <= '1;
    end else begin
      display_q   <= display_d;
      ovf_q       <= ovf_d;
      prescaler_q <= prescaler_d;
      digitSel_q  <= digitSel_d;
      bcdOut_q    <= bcdOut_d;
      csN_q       <= csN_d;
    end
  end

  assign temp_ready   = convReady;
  assign {A, B, C, D} = bcdOut_q;
  assign cs_n         = csN_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_temp_display_scanner.sv
// Self-checking bench for temp_display_scanner: a behavioural model of the
// display (value, slot timing by absolute cycle count) checked every cycle,
// plus literal digit checks and a second two-digit overflow configuration.
module tb_temp_display_scanner;

  localparam int DW  = 8;
  localparam int ND  = 3;
  localparam int RD  = 4;
  localparam int DW2 = 10;
  localparam int ND2 = 2;
  localparam int RD2 = 2;

  logic clk = 1'b0;
  logic rst_n;

  logic [DW-1:0]  tempBin;
  logic           tempValid;
  logic           tempReady;
  logic           a, b, c, d;
  logic [ND-1:0]  csN;
  logic           ovfOut;

  logic [DW2-1:0] t2Bin;
  logic           t2Valid;
  logic           t2Ready;
  logic           a2, b2, c2, d2;
  logic [ND2-1:0] cs2N;
  logic           ovf2;

  int checks = 0;
  int errors = 0;

  temp_display_scanner #(
    .DATA_W(DW), .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_LEADING(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .temp_bin(tempBin), .temp_valid(tempValid),
    .temp_ready(tempReady), .A(a), .B(b), .C(c), .D(d), .cs_n(csN), .ovf(ovfOut)
  );

  temp_display_scanner #(
    .DATA_W(DW2), .NUM_DIGITS(ND2), .REFRESH_DIV(RD2), .BLANK_LEADING(1)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .temp_bin(t2Bin), .temp_valid(t2Valid),
    .temp_ready(t2Ready), .A(a2), .B(b2), .C(c2), .D(d2), .cs_n(cs2N), .ovf(ovf2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Behavioural model of the main instance
  int          pow10 [4] = '{1, 10, 100, 1000};
  bit          mInit = 1'b0;
  bit          mReady;
  int          mCnt, mPend, mDisp, mTick;
  logic        mOvf;
  logic [3:0]  mBcd;
  logic [2:0]  mCs;
  logic        capRst = 1'b1;
  logic        capValid = 1'b0;
  logic [DW-1:0] capBin = '0;

  // Capture the inputs the DUT saw at each rising edge
  always @(posedge clk) begin
    capRst   <= rst_n;
    capValid <= tempValid;
    capBin   <= tempBin;
  end

  // Advance the model by one edge and compare all outputs every cycle
  always @(negedge clk) begin : compareProc
    int slot;
    if (capRst === 1'b0) begin
      mReady = 1'b1; mCnt = 0; mDisp = 0; mOvf = 1'b0; mTick = 0;
      mCs = 3'b111; mBcd = 4'd0; mInit = 1'b1;
    end else if (mInit) begin
      slot  = (mTick / RD) % ND;
      mBcd  = 4'((mDisp / pow10[slot]) % 10);
      mCs   = 3'b111;
      if (!(slot > 0 && mDisp < pow10[slot])) mCs[slot] = 1'b0;
      mTick++;
      if (mReady) begin
        if (capValid === 1'b1) begin
          mPend = int'(capBin); mCnt = DW + 1; mReady = 1'b0;
        end
      end else begin
        mCnt--;
        if (mCnt == 0) begin
          if (mPend > pow10[ND] - 1) begin mDisp = pow10[ND] - 1; mOvf = 1'b1; end
          else begin mDisp = mPend; mOvf = 1'b0; end
          mReady = 1'b1;
        end
      end
    end
    if (mInit) begin
      checkOutput("model_ready", tempReady, mReady);
      checkOutput("model_abcd", {a, b, c, d}, mBcd);
      checkOutput("model_cs_n", csN, mCs);
      checkOutput("model_ovf", ovfOut, mOvf);
    end
  end

  task automatic applyStimulus(input int value);
    int n = 0;
    while (tempReady !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("[TB] FAIL ready_wait: temp_ready=%0d after %0d cycles, required 1", tempReady, n);
    end
    tempBin = DW'(value);
    tempValid = 1'b1;
    @(negedge clk);
    tempValid = 1'b0;
  endtask

  task automatic waitDone(input int expLat);
    int n = 0;
    while (tempReady !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (expLat >= 0) checkOutput("latency", n, expLat);
    else if (n >= 50) begin
      checks++; errors++;
      $display("[TB] FAIL done_wait: temp_ready=%0d after %0d cycles, required 1", tempReady, n);
    end
    @(negedge clk);
  endtask

  task automatic checkDigit(input string name, input logic [2:0] cs, input logic [3:0] val);
    int n = 0;
    while (csN !== cs && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) begin
      checks++; errors++;
      $display("[TB] FAIL %s_slot: cs_n=%b never became required %b", name, csN, cs);
    end else begin
      checkOutput(name, {a, b, c, d}, val);
    end
  endtask

  task automatic checkDigit2(input string name, input logic [1:0] cs, input logic [3:0] val);
    int n = 0;
    while (cs2N !== cs && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) begin
      checks++; errors++;
      $display("[TB] FAIL %s_slot: cs_n=%b never became required %b", name, cs2N, cs);
    end else begin
      checkOutput(name, {a2, b2, c2, d2}, val);
    end
  endtask

  task automatic applyStimulus2(input int value);
    int n = 0;
    t2Bin = DW2'(value);
    t2Valid = 1'b1;
    @(negedge clk);
    t2Valid = 1'b0;
    while (t2Ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checkOutput("i2_latency", n, DW2 + 1);
    @(negedge clk);
  endtask

  // Time limit so a hung DUT still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog");
  end

  // Directed and random stimulus
  initial begin
    rst_n = 1'b0; tempValid = 1'b0; tempBin = '0; t2Valid = 1'b0; t2Bin = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cs_n", csN, 3'b111);
    checkOutput("rst_abcd", {a, b, c, d}, 4'd0);
    checkOutput("rst_ready", tempReady, 1);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_slot0_cs", csN, 3'b110);
    checkOutput("idle_slot0_abcd", {a, b, c, d}, 4'd0);
    repeat (4) @(negedge clk);
    checkOutput("idle_slot1_cs", csN, 3'b111);
    repeat (4) @(negedge clk);
    checkOutput("idle_slot2_cs", csN, 3'b111);
    repeat (4) @(negedge clk);
    checkOutput("idle_wrap_cs", csN, 3'b110);

    $display("[TB] sample 37");
    applyStimulus(37);
    checkOutput("busy_ready", tempReady, 0);
    waitDone(DW + 1);
    checkDigit("d37_units", 3'b110, 4'd7);
    checkDigit("d37_tens", 3'b101, 4'd3);
    checkOutput("d37_ovf", ovfOut, 0);

    $display("[TB] sample 255");
    applyStimulus(255);
    waitDone(DW + 1);
    checkDigit("d255_units", 3'b110, 4'd5);
    checkDigit("d255_tens", 3'b101, 4'd5);
    checkDigit("d255_hund", 3'b011, 4'd2);

    $display("[TB] busy sample ignored");
    applyStimulus(12);
    repeat (2) @(negedge clk);
    tempBin = 8'd99; tempValid = 1'b1;
    @(negedge clk);
    tempValid = 1'b0;
    waitDone(DW + 1 - 3);
    checkDigit("d12_units", 3'b110, 4'd2);
    checkDigit("d12_tens", 3'b101, 4'd1);
    applyStimulus(99);
    waitDone(DW + 1);
    checkDigit("d99_units", 3'b110, 4'd9);
    checkDigit("d99_tens", 3'b101, 4'd9);

    $display("[TB] reset during conversion");
    applyStimulus(200);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_ready", tempReady, 1);
    checkOutput("abort_ovf", ovfOut, 0);
    checkOutput("abort_cs_n", csN, 3'b111);
    repeat (15) @(negedge clk);
    checkDigit("abort_units", 3'b110, 4'd0);
    checkOutput("abort_ready_late", tempReady, 1);

    $display("[TB] random phase");
    repeat (600) begin
      @(negedge clk);
      tempValid = ($urandom_range(0, 3) == 0);
      tempBin = DW'($urandom);
    end
    tempValid = 1'b0;
    repeat (15) @(negedge clk);

    $display("[TB] two-digit overflow configuration");
    applyStimulus2(150);
    checkOutput("i2_ovf_150", ovf2, 1);
    checkDigit2("i2_150_units", 2'b10, 4'd9);
    checkDigit2("i2_150_tens", 2'b01, 4'd9);
    applyStimulus2(42);
    checkOutput("i2_ovf_42", ovf2, 0);
    checkDigit2("i2_42_units", 2'b10, 4'd2);
    checkDigit2("i2_42_tens", 2'b01, 4'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/temp_display_scanner.md
Name: temp_display_scanner

Overview:
- Upstream stage of the per-digit seven_segment decoder in the temperature-sensor display path.
- Accepts a binary temperature reading over a valid/ready handshake and converts it to BCD sequentially (shift-add-3).
- Time-multiplexes the digits onto one shared BCD bus A,B,C,D with an active-low per-digit select cs_n.
- The display keeps refreshing with the previous value while a new conversion runs.

Parameters:
DATA_W, 8, width of binary temperature input
NUM_DIGITS, 3, number of display digits; digit 0 = units
REFRESH_DIV, 1000, clock cycles each digit stays selected
BLANK_LEADING, 1, 1 = suppress leading-zero digits (never digit 0)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
temp_bin  input  DATA_W  binary temperature, unsigned
temp_valid  input  1  temp_bin valid
temp_ready  output  1  block can accept a new sample
A  output  1  BCD bit 3 (MSB) of selected digit
B  output  1  BCD bit 2
C  output  1  BCD bit 1
D  output  1  BCD bit 0 (LSB)
cs_n  output  NUM_DIGITS  active-low digit select, at most one bit low
ovf  output  1  last committed sample exceeded 10^NUM_DIGITS-1

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active-low, sampled on the clk rising edge.
- Reset (rst_n=0 at an edge):
  - state=IDLE, temp_ready=1.
  - Display register and ovf cleared to 0.
  - Prescaler=0, digit_sel=0, A..D=0, cs_n=all ones.
  - Reset mid-conversion aborts the conversion; no partial commit.
- FSM states:
  - IDLE: temp_ready=1. On an edge with temp_valid=1, capture temp_bin, clear BCD accumulator and bit counter, go to CONVERT.
  - CONVERT: temp_ready=0. On each edge, add 3 to every BCD nibble >=5, then shift left one bit, bringing in the next temp_bin bit MSB-first. After exactly DATA_W edges, go to COMMIT.
  - COMMIT: temp_ready=0. One edge; copy the BCD result to the display register, update ovf, return to IDLE.
- Latency: handshake accepted at edge N; display register and ovf update at edge N+DATA_W+1; temp_ready is high again after that edge.
- Busy: temp_valid while temp_ready=0 is ignored and not queued.
- Overflow: a result exceeding NUM_DIGITS digits is committed as all digits 9 with ovf=1. Otherwise ovf=0. The accumulator carries enough extra nibbles to detect this.
- Scanner (runs continuously from reset, independent of the FSM):
  - Prescaler counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit_sel increments modulo NUM_DIGITS, sequence 0,1,..,NUM_DIGITS-1,0.
- Outputs are registered, one-cycle delayed from digit_sel/display:
  - {A,B,C,D} = nibble of the selected digit.
  - cs_n[digit_sel]=0, all other bits 1.
- Leading blank: with BLANK_LEADING=1, a digit k>0 whose nibble and all higher nibbles are 0 drives cs_n all ones during its slot; A..D still carry 0. Digit 0 is never blanked.
- Commit during a scan slot: the new nibble appears on A..D at the next edge; the slot timing is unaffected.
- All arithmetic is unsigned; nibble values are always 0..9.

Decomposition:
- Shared package temp_disp_pkg:
  - FSM state enum {IDLE, CONVERT, COMMIT}.
  - BCD_W=4.
  - Localparam function computing accumulator width from DATA_W.
- One sub-module: bin2bcd_seq, containing the CONVERT/COMMIT datapath with start/done.
- Prescaler, digit scan and blanking stay in the top module.

Test Plan:
- Reset, REFRESH_DIV=4, no sample:
  - during reset cs_n=111, A..D=0;
  - after release cs_n=110 with A..D=0, then 111 twice (digits 1 and 2 blanked), repeating every 4 cycles per slot.
- temp_bin=37 at edge N:
  - temp_ready low at edges N..N+8, display updates at edge N+9;
  - scan shows 0111 with cs_n=110, 0011 with cs_n=101, hundreds blanked with cs_n=111; ovf=0.
- temp_bin=255:
  - slots show 0101, 0101, 0010, all three digits enabled.
- temp_valid=1 with 99 while a conversion of 12 is busy:
  - 99 is ignored; display shows 12;
  - a later handshake with 99 shows 99.
- Reset asserted at the 4th CONVERT edge of sample 200:
  - display stays 0, ovf=0, temp_ready=1 after reset.
- DATA_W=10, NUM_DIGITS=2, temp_bin=150:
  - displays 9,9 with ovf=1;
  - a subsequent 42 clears ovf and shows 2,4.
